// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, bidirectional shift, clear, clock enable,
// with a shift counter that pulses frame_done after every WIDTH shifts.
module shift_reg_univ #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [1:0]                 mode,
  input  logic                       sin_lo,
  input  logic                       sin_hi,
  input  logic [WIDTH-1:0]           pdata,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_lo,
  output logic                       sout_hi,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       frame_done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [1:0] M_HOLD = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  localparam logic [1:0] M_LD   = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  logic [WIDTH-1:0] q_up, q_dn;
  logic             cnt_wrap;

  assign q_up     = {q[WIDTH-2:0], sin_lo};
  assign q_dn     = {sin_hi, q[WIDTH-1:1]};
  assign cnt_wrap = (shift_cnt == CNT_LAST);
  assign sout_lo  = q[0];
  assign sout_hi  = q[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (clr) begin
      q          <= RESET_VAL;
      shift_cnt  <= '0;
      frame_done <= 1'b0;
    end else if (!en) begin
      // disabled cycles still drop frame_done so a pulse never stretches
      frame_done <= 1'b0;
    end else begin
      case (mode)
        M_HOLD: frame_done <= 1'b0;
        M_UP, M_DN: begin
          q          <= (mode == M_UP) ? q_up : q_dn;
          shift_cnt  <= cnt_wrap ? '0 : shift_cnt + 1'b1;
          frame_done <= cnt_wrap;
        end
        M_LD: begin
          q          <= pdata;
          shift_cnt  <= '0;
          frame_done <= 1'b0;
        end
        default: frame_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus a random phase,
// all compared against an arithmetic reference model of the register.
module tb_shift_reg_univ;
  localparam int W  = 16;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n, en, clr, sin_lo, sin_hi;
  logic [1:0]    mode;
  logic [W-1:0]  pdata, q;
  logic          sout_lo, sout_hi, frame_done;
  logic [CW-1:0] shift_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: register value as a plain integer, shifts counted as an integer
  longint m_q;
  int     m_cnt;
  bit     m_fd;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL('0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .sin_lo(sin_lo), .sin_hi(sin_hi), .pdata(pdata), .q(q),
    .sout_lo(sout_lo), .sout_hi(sout_hi), .shift_cnt(shift_cnt),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_cnt = 0; m_fd = 0;
  endtask

  task automatic model_edge();
    longint full;
    full = longint'(1) << W;
    if (!rst_n || clr) model_reset();
    else if (!en) m_fd = 0;
    else if (mode == 2'd3) begin
      m_q = longint'(pdata); m_cnt = 0; m_fd = 0;
    end else if (mode == 2'd0) m_fd = 0;
    else begin
      if (mode == 2'd1) m_q = (m_q * 2 + longint'(sin_lo)) % full;
      else              m_q = m_q / 2 + longint'(sin_hi) * (full / 2);
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin m_cnt = 0; m_fd = 1; end
      else m_fd = 0;
    end
  endtask

  task automatic check_all(input string tag);
    longint half;
    half = longint'(1) << (W-1);
    check({tag, ".q"},          64'(q),          64'(m_q));
    check({tag, ".sout_lo"},    64'(sout_lo),    64'(m_q % 2));
    check({tag, ".sout_hi"},    64'(sout_hi),    64'(m_q / half));
    check({tag, ".shift_cnt"},  64'(shift_cnt),  64'(m_cnt));
    check({tag, ".frame_done"}, 64'(frame_done), 64'(m_fd));
  endtask

  // one clock: model follows the inputs seen at the edge, outputs sampled 1 time unit later
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m,
                       input logic sl, input logic sh, input logic [W-1:0] pd);
    en = e; clr = c; mode = m; sin_lo = sl; sin_hi = sh; pdata = pd;
  endtask

  initial begin
    logic [W-1:0] pat;
    int pulses;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0);
    model_reset();

    // reset held while all inputs toggle
    for (int i = 0; i < 5; i++) begin
      drive(1'(i), 1'(i >> 1), 2'(i), 1'(~i), 1'(i), W'($urandom));
      step("reset");
      check("reset.q_zero", 64'(q), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // load 0xA5C3
    pat = 16'hA5C3;
    drive(1, 0, 2'b11, 0, 0, pat);
    step("load");
    check("load.q", 64'(q), 64'hA5C3);

    // shift up with sin_lo=1: sout_hi walks bits 15..0 of the loaded word
    for (int i = 0; i < W; i++) begin
      check("up.sout_hi_seq", 64'(sout_hi), 64'(pat[W-1-i]));
      drive(1, 0, 2'b01, 1, 0, '0);
      step("up");
    end
    check("up.q_ffff", 64'(q), 64'hFFFF);
    check("up.fd_pulse", 64'(frame_done), 64'h1);
    check("up.cnt_wrap", 64'(shift_cnt), 64'h0);
    drive(1, 0, 2'b00, 0, 0, '0);
    step("hold");
    check("hold.fd_drop", 64'(frame_done), 64'h0);

    // shift down from 0x8001
    drive(1, 0, 2'b11, 0, 0, 16'h8001);
    step("load2");
    check("dn.sout_lo_pre", 64'(sout_lo), 64'h1);
    drive(1, 0, 2'b10, 0, 0, '0);
    step("dn");
    check("dn.q1", 64'(q), 64'h4000);
    step("dn");
    check("dn.q2", 64'(q), 64'h2000);
    step("dn");
    check("dn.q3", 64'(q), 64'h1000);
    check("dn.sout_lo_post", 64'(sout_lo), 64'h0);

    // enable gating: 10 cycles, 5 enabled
    drive(1, 0, 2'b11, 0, 0, '0);
    step("load3");
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2 == 0), 0, 2'b01, 1'($urandom), 0, '0);
      step("gated");
    end
    check("gated.cnt5", 64'(shift_cnt), 64'd5);
    drive(0, 1, 2'b01, 1, 1, '0);
    step("clr");
    check("clr.q", 64'(q), 64'h0);
    check("clr.cnt", 64'(shift_cnt), 64'h0);
    pulses = 0;
    for (int i = 0; i < W; i++) begin
      drive(1, 0, 2'b01, 1'($urandom), 0, '0);
      step("frame");
      pulses += int'(frame_done);
    end
    drive(1, 0, 2'b00, 0, 0, '0);
    step("frame_hold");
    pulses += int'(frame_done);
    check("frame.one_pulse", 64'(pulses), 64'd1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 29) == 0),
            2'($urandom), 1'($urandom), 1'($urandom), W'($urandom));
      step("rand");
    end

    // async reset mid-frame after 15 shifts
    drive(1, 0, 2'b11, 0, 0, 16'h1234);
    step("load4");
    for (int i = 0; i < W-1; i++) begin
      drive(1, 0, 2'($urandom_range(1, 2)), 1'($urandom), 1'($urandom), '0);
      step("pre_rst");
    end
    check("pre_rst.cnt15", 64'(shift_cnt), 64'd15);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 2'b01, 1, 0, '0);
    step("post_rst");
    check("post_rst.no_fd", 64'(frame_done), 64'h0);
    check("post_rst.cnt1", 64'(shift_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
